// File: rtl/fc_vec_packer.sv
// fc_vec_packer: rescales, saturates and optionally ReLUs a serial stream of FC accumulator sums
//   and packs one frame of OUT_LENGTH results into a single wide vector.
// Latency: data_out/data_out_valid update one cycle after the completing beat if the emission gap has expired.
// Backpressure: in_ready is low only while a completed frame waits for the MIN_GAP emission spacing.
// Ports: clk, rst_n (async, active-low);
//   in_data/in_valid/in_last/in_ready : accumulator beat stream, one neuron per beat;
//   data_out/data_out_valid : packed vector (slot k at [DATA_W*k +: DATA_W]) + one-cycle pulse;
//   frame_err : one-cycle pulse on a short frame or a missing in_last.
module fc_vec_packer #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int OUT_LENGTH = 32,
  parameter int SHIFT      = 12,
  parameter int RELU       = 1,
  parameter int ROT        = 2,
  parameter int MIN_GAP    = 140
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [ACC_W-1:0]      in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [DATA_W*OUT_LENGTH-1:0] data_out,
  output logic                         data_out_valid,
  output logic                         frame_err
);

  localparam int IDX_W = (OUT_LENGTH > 1) ? $clog2(OUT_LENGTH) : 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int ROT_M = ROT % OUT_LENGTH;
  localparam int VEC_W = DATA_W * OUT_LENGTH;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_PENDING = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   fill_q, fill_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               err_pend_q, err_pend_d;
  logic [VEC_W-1:0]   data_out_q, data_out_d;
  logic               data_out_valid_q, emit;
  logic               frame_err_q;

  logic                     accept;
  logic                     gap_ok;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        sat_val;
  logic [DATA_W-1:0]        res_val;
  logic [IDX_W:0]           slot_sum;
  logic [IDX_W-1:0]         slot;

  // Per-beat arithmetic: rescale, saturate to DATA_W, optional ReLU.
  assign shifted = in_data >>> SHIFT;

  always_comb begin
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_val = shifted[DATA_W-1:0];
    end
  end

  assign res_val = ((RELU != 0) && sat_val[DATA_W-1]) ? '0 : sat_val;

  // Rotated slot: (idx + ROT) mod OUT_LENGTH, one conditional subtract suffices.
  assign slot_sum = {1'b0, idx_q} + (IDX_W+1)'(ROT_M);
  assign slot     = (slot_sum >= (IDX_W+1)'(OUT_LENGTH))
                    ? IDX_W'(slot_sum - (IDX_W+1)'(OUT_LENGTH))
                    : IDX_W'(slot_sum);

  // EMIT itself takes a cycle, so a frame may head for EMIT one cycle before
  // the counter reaches zero; the resulting pulse still lands on expiry.
  assign gap_ok   = (gap_q <= GAP_W'(1));
  assign in_ready = (state_q != S_PENDING);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    err_pend_d = 1'b0;
    emit       = 1'b0;
    data_out_d = data_out_q;
    gap_d      = gap_q;

    if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end

    case (state_q)
      S_PENDING: begin
        if (gap_ok) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // Copy the pre-write buffer; a beat taken now belongs to the next frame.
        data_out_d = fill_q;
        emit       = 1'b1;
        gap_d      = GAP_W'(MIN_GAP - 1);
        state_d    = S_FILL;
      end
      default: ;
    endcase

    if (accept) begin
      fill_d[slot*DATA_W +: DATA_W] = res_val;
      if (idx_q == IDX_W'(OUT_LENGTH - 1)) begin
        idx_d      = '0;
        err_pend_d = !in_last;
        state_d    = (state_q == S_FILL && gap_ok) ? S_EMIT : S_PENDING;
      end else if (in_last) begin
        // Short frame: drop it; stale slots are overwritten by the next full frame.
        idx_d      = '0;
        err_pend_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_FILL;
      idx_q            <= '0;
      fill_q           <= '0;
      gap_q            <= '0;
      err_pend_q       <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      frame_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      fill_q           <= fill_d;
      gap_q            <= gap_d;
      err_pend_q       <= err_pend_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= emit;
      // Delayed one extra stage so a missing-in_last error lines up with the emission pulse.
      frame_err_q      <= err_pend_q;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_fc_vec_packer.sv
module tb_fc_vec_packer;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int L       = 32;
  localparam int SHIFT   = 12;
  localparam int ROT     = 2;
  localparam int MIN_GAP = 140;
  localparam int VW      = DATA_W * L;

  typedef struct {
    bit            vld;
    bit            err;
    longint        cyc;
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
  } ev_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [ACC_W-1:0] in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic                    in_ready, in_ready1;
  logic [VW-1:0]           dout0, dout1;
  logic                    dov0, dov1, ferr0, ferr1;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_pulse = -1000;
  bit     done = 1'b0;

  logic signed [ACC_W-1:0] fv [L];
  ev_t           exp_q [$];
  ev_t           mon_e;
  longint        pulse_cyc [$];
  logic [VW-1:0] cur0 = '0, cur1 = '0, cap0 = '0, cap1 = '0;

  fc_vec_packer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_LENGTH(L), .SHIFT(SHIFT),
                  .RELU(1), .ROT(ROT), .MIN_GAP(MIN_GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .data_out(dout0), .data_out_valid(dov0), .frame_err(ferr0));

  fc_vec_packer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_LENGTH(L), .SHIFT(SHIFT),
                  .RELU(0), .ROT(ROT), .MIN_GAP(MIN_GAP)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready1), .data_out(dout1), .data_out_valid(dov1), .frame_err(ferr1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slot_of(input logic [VW-1:0] v, input int k);
    return v[k*DATA_W +: DATA_W];
  endfunction

  // Reference arithmetic: shift, clamp to 16-bit signed range, optional ReLU.
  function automatic logic [DATA_W-1:0] ref_val(input logic signed [ACC_W-1:0] a, input bit relu);
    longint s;
    s = longint'(a) >>> SHIFT;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [VW-1:0] model_vec(input bit relu);
    logic [VW-1:0] v;
    v = '0;
    for (int n = 0; n < L; n++) v[((n + ROT) % L)*DATA_W +: DATA_W] = ref_val(fv[n], relu);
    return v;
  endfunction

  // Present one beat; returns the clk edge number at which it was accepted.
  task automatic send_beat(input logic [ACC_W-1:0] d, input bit lst, output longint t);
    int w;
    w = 0;
    @(negedge clk);
    in_data = d; in_valid = 1'b1; in_last = lst;
    while (!in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("beat_ready", in_ready, 1);
    t = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int nb, input bit last_at_end, output longint t_last);
    longint t, pc;
    bit     lst;
    ev_t    e;
    t = 0;
    for (int n = 0; n < nb; n++) begin
      lst = last_at_end && (n == nb - 1);
      send_beat(fv[n], lst, t);
      if (n == L - 1) begin
        pc = (t + 1 > last_pulse + MIN_GAP) ? t + 1 : last_pulse + MIN_GAP;
        e.v0 = model_vec(1'b1);
        e.v1 = model_vec(1'b0);
        if (!lst && pc != t + 1) begin
          e.vld = 1'b0; e.err = 1'b1; e.cyc = t + 1;
          exp_q.push_back(e);
        end
        e.vld = 1'b1; e.err = !lst && (pc == t + 1); e.cyc = pc;
        exp_q.push_back(e);
        last_pulse = pc;
      end else if (lst) begin
        e.vld = 1'b0; e.err = 1'b1; e.cyc = t + 1; e.v0 = '0; e.v1 = '0;
        exp_q.push_back(e);
      end
    end
    t_last = t;
  endtask

  task automatic wait_pulses(input int target);
    int w;
    w = 0;
    while (pulse_cyc.size() < target && w < 2000) begin
      @(posedge clk);
      w++;
    end
    chk("pulse_count", pulse_cyc.size(), target);
  endtask

  // Monitor: every output event is matched against the next expected event.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur0 <= '0;
      cur1 <= '0;
    end else begin
      if (dov0 || ferr0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event cyc %0d vld %0b err %0b", cyc, dov0, ferr0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ev_cycle", cyc, mon_e.cyc);
          chk("ev_valid", dov0, mon_e.vld);
          chk("ev_err", ferr0, mon_e.err);
          chk("ev_valid_nr", dov1, mon_e.vld);
          if (mon_e.vld) begin
            cur0 = mon_e.v0;
            cur1 = mon_e.v1;
            cap0 = dout0;
            cap1 = dout1;
            pulse_cyc.push_back(cyc);
          end
        end
      end
      chk_vec("dout_relu", dout0, cur0);
      chk_vec("dout_norelu", dout1, cur1);
    end
  end

  initial begin
    #400000;
    if (!done) begin
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
    end
  end

  initial begin
    longint t, prev;
    int     n_low;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", dov0, 0);
    chk("rst_err", ferr0, 0);
    chk_vec("rst_dout", dout0, '0);
    rst_n = 1'b1;

    // Rotation: neuron n -> n after the shift
    for (int n = 0; n < L; n++) fv[n] = 32'(n * 4096);
    send_frame(L, 1'b1, t);
    wait_pulses(1);
    chk("rot_latency", pulse_cyc[0], t + 1);
    chk("rot_slot2", slot_of(cap0, 2), 16'd0);
    chk("rot_slot3", slot_of(cap0, 3), 16'd1);
    chk("rot_slot31", slot_of(cap0, 31), 16'd29);
    chk("rot_slot0", slot_of(cap0, 0), 16'd30);
    chk("rot_slot1", slot_of(cap0, 1), 16'd31);

    // Saturation in both ReLU settings
    for (int n = 0; n < L; n++) fv[n] = 32'((n - 16) * 100000);
    fv[0] = 32'h7FFF_FFFF;
    fv[1] = 32'h8000_0000;
    fv[2] = -32'sd4096;
    send_frame(L, 1'b1, t);
    wait_pulses(2);
    chk("sat_relu_s2", slot_of(cap0, 2), 16'h7FFF);
    chk("sat_relu_s3", slot_of(cap0, 3), 16'h0000);
    chk("sat_relu_s4", slot_of(cap0, 4), 16'h0000);
    chk("sat_nr_s2", slot_of(cap1, 2), 16'h7FFF);
    chk("sat_nr_s3", slot_of(cap1, 3), 16'h8000);
    chk("sat_nr_s4", slot_of(cap1, 4), 16'hFFFF);

    // Gap: frame completes early, waits with in_ready low
    prev = last_pulse;
    repeat (7) @(negedge clk);
    for (int n = 0; n < L; n++) fv[n] = 32'(50000 - n * 3000);
    send_frame(L, 1'b1, t);
    n_low = 0;
    @(negedge clk);
    while (!in_ready && n_low < 500) begin
      n_low++;
      @(negedge clk);
    end
    chk("gap_ready_low", n_low, prev + MIN_GAP - 1 - t);
    wait_pulses(3);
    chk("gap_spacing", pulse_cyc[2] - pulse_cyc[1], 140);

    // Short frame: in_last at idx 9
    for (int n = 0; n < L; n++) fv[n] = 32'(n * 777777);
    send_frame(10, 1'b1, t);
    repeat (3) @(negedge clk);
    chk("short_no_pulse", pulse_cyc.size(), 3);
    for (int n = 0; n < L; n++) fv[n] = 32'(n * 123457) - 32'd2000000;
    send_frame(L, 1'b1, t);
    wait_pulses(4);

    // Missing in_last with gap expired: error and pulse together
    repeat (150) @(negedge clk);
    for (int n = 0; n < L; n++) fv[n] = 32'(n) <<< 16;
    send_frame(L, 1'b0, t);
    wait_pulses(5);
    chk("nolast_same_cycle", pulse_cyc[4], t + 1);

    // Reset mid-frame
    for (int n = 0; n < L; n++) fv[n] = 32'h7FFF_FFFF;
    send_frame(20, 1'b0, t);
    @(negedge clk);
    rst_n = 1'b0;
    last_pulse = -1000;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_valid", dov0, 0);
    chk("mrst_err", ferr0, 0);
    chk("mrst_idx", u_dut.idx_q, 0);
    chk_vec("mrst_dout", dout0, '0);
    chk_vec("mrst_dout_nr", dout1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < L; n++) fv[n] = -32'(n * 4096);
    send_frame(L, 1'b1, t);
    wait_pulses(6);
    chk("post_rst_latency", pulse_cyc[5], t + 1);
    chk("post_rst_relu_s5", slot_of(cap0, 5), 16'h0000);
    chk("post_rst_nr_s5", slot_of(cap1, 5), 16'hFFFD);

    repeat (5) @(negedge clk);
    chk("events_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
